// File: rtl/box_arb_pkg.sv
// ============================================================================
// Module      : box_arb_pkg
// Description : Shared constants, state type and helpers for box_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package box_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/box_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick. Rotates req so that bit ptr
//               sits at position 0, priority-encodes the lowest set bit and
//               adds ptr back to recover the absolute index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import box_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] w_rot;
  logic [SEL_W-1:0]   w_off;

  // Rotate so the search starts at ptr; index arithmetic wraps mod 8.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_rot[k] = req[ptr + SEL_W'(k)];
    end
  end

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = SEL_W'(k);
      end
    end
  end

  assign idx = ptr + w_off;
  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/box_arbiter.sv
// ============================================================================
// Module      : box_arbiter
// Description : Packet-granular round-robin scheduler for the shared 8-input
//               box datapath, with a registered valid/ready output stage and
//               a stall timeout that releases a requester stuck mid-packet.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module box_arbiter
  import box_arb_pkg::*;
#(
  parameter int WIREWIDTH = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   last,
  input  logic [WIREWIDTH:0]   d0,
  input  logic [WIREWIDTH:0]   d1,
  input  logic [WIREWIDTH:0]   d2,
  input  logic [WIREWIDTH:0]   d3,
  input  logic [WIREWIDTH:0]   d4,
  input  logic [WIREWIDTH:0]   d5,
  input  logic [WIREWIDTH:0]   d6,
  input  logic [WIREWIDTH:0]   d7,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [SEL_W-1:0]     sel,
  output logic [WIREWIDTH:0]   o,
  output logic                 o_valid,
  output logic                 o_last,
  input  logic                 o_ready,
  output logic                 err
);

  localparam int             CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit             TO_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W:0] TO_VAL = (CNT_W + 1)'(TIMEOUT);

  state_e               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [SEL_W-1:0]     sel_q;
  logic [SEL_W-1:0]     ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIREWIDTH:0]   o_q;
  logic                 o_valid_q;
  logic                 o_last_q;
  logic                 err_q;

  logic [WIREWIDTH:0]   w_d [NUM_REQ];
  logic [WIREWIDTH:0]   w_sel_d;
  logic                 w_any;
  logic [SEL_W-1:0]     w_idx;
  logic                 w_ld;
  logic                 w_busy;
  logic                 w_take;
  logic                 w_stall;
  logic [CNT_W:0]       w_cnt_nxt;
  logic [CNT_W-1:0]     w_cnt_sat;
  logic                 w_timeout;

  assign w_d[0] = d0;
  assign w_d[1] = d1;
  assign w_d[2] = d2;
  assign w_d[3] = d3;
  assign w_d[4] = d4;
  assign w_d[5] = d5;
  assign w_d[6] = d6;
  assign w_d[7] = d7;
  assign w_sel_d = w_d[sel_q];

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (w_any),
    .idx (w_idx)
  );

  // The output register can accept a new beat when empty or draining.
  assign w_ld    = !o_valid_q | o_ready;
  assign w_busy  = (state_q == BUSY);
  assign w_take  = w_busy & req[sel_q] & w_ld;
  // Backpressure (w_ld low) is not a requester stall.
  assign w_stall = w_busy & !req[sel_q] & w_ld;

  assign w_cnt_nxt = {1'b0, cnt_q} + 1'b1;
  assign w_cnt_sat = (&cnt_q) ? cnt_q : w_cnt_nxt[CNT_W-1:0];
  assign w_timeout = TO_EN & w_stall & (w_cnt_nxt == TO_VAL);

  assign ack     = w_take ? onehot(sel_q) : '0;
  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign err     = err_q;

  // Grant FSM: pick in IDLE, hold through the packet, release on last/timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (w_any) begin
            state_q <= BUSY;
            gnt_q   <= onehot(w_idx);
            sel_q   <= w_idx;
          end
        end
        BUSY: begin
          if (w_take) begin
            cnt_q <= '0;
            if (last[sel_q]) begin
              state_q <= IDLE;
              gnt_q   <= '0;
              ptr_q   <= sel_q + 1'b1;
            end
          end else if (w_stall) begin
            if (w_timeout) begin
              state_q <= IDLE;
              gnt_q   <= '0;
              ptr_q   <= sel_q + 1'b1;
              cnt_q   <= '0;
              err_q   <= 1'b1;
            end else begin
              cnt_q <= w_cnt_sat;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output stage: load a taken beat, otherwise drain on o_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q       <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else if (w_take) begin
      o_q       <= w_sel_d;
      o_valid_q <= 1'b1;
      o_last_q  <= last[sel_q];
    end else if (o_ready) begin
      o_valid_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/box_arbiter.md
# box_arbiter

Round-robin scheduler that shares the 8-input `box` datapath between eight requesters. Grants one requester at a time and holds the grant for a whole packet. Drives the select for the shared path. Registers the selected beat onto a valid/ready output stream. A hold-timeout releases a requester that stalls mid-packet.

## Interface
- `WIREWIDTH`, default 1: data ports are `[WIREWIDTH:0]`, i.e. WIREWIDTH+1 bits.
- `TIMEOUT`, default 15: consecutive stalled cycles before forced release; 0 disables the timeout.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input 8: per-requester beat valid; bit i pairs with `di`.
- `last` input 8: per-requester final-beat flag, sampled with `req`.
- `d0`..`d7` input WIREWIDTH+1 each: requester data.
- `ack` output 8: combinational; bit i high when requester i's beat is taken this cycle.
- `gnt` output 8: registered one-hot grant; all-zero when idle.
- `sel` output 3: registered index of the granted requester.
- `o` output WIREWIDTH+1: registered output data.
- `o_valid` output 1: output beat valid.
- `o_last` output 1: output beat is end of packet.
- `o_ready` input 1: downstream accepts a beat when `o_valid & o_ready`.
- `err` output 1: one-cycle pulse on timeout release.

## Operation
- **State reset (`rst_n`=0):**
  - IDLE, `gnt`=0, `sel`=0, `ptr`=0, stall count=0.
- **Output reset (`rst_n`=0):**
  - `o`=0, `o_valid`=0, `o_last`=0, `err`=0.
- **Output load enable:** `ld = !o_valid | o_ready`.
- **IDLE:**
  - If `req` is nonzero, pick the first set bit searching `ptr`, `ptr+1`, … mod 8.
  - Next cycle: BUSY, `gnt` = one-hot of the winner, `sel` = winner.
  - Nothing is taken in IDLE: `ack`=0.
- **BUSY, beat taken** when `req[sel] & ld`; then `ack[sel]`=1.
  - Update `o` <= `d[sel]`, `o_valid` <= 1, `o_last` <= `last[sel]`.
  - Stall count clears.
- **BUSY, taken with `last[sel]`:**
  - Next cycle IDLE, `gnt` <= 0, `ptr` <= `sel+1`, wrapping 7->0.
- **BUSY, `req[sel]`=0:**
  - Stall count increments and saturates.
  - When it reaches `TIMEOUT` (TIMEOUT>0): go IDLE, `ptr` <= `sel+1`, `err` pulses for one cycle, count clears.
  - A release does not emit a synthetic `o_last`.
- **Backpressure:** while `ld`=0, nothing is taken and the stall count holds. Downstream backpressure is not a requester stall.
- **Output drain:** when `o_valid & o_ready` and no new beat is loaded, `o_valid` <= 0. The output register drains normally in IDLE.
- **Non-granted requesters:** `req` is ignored and `ack` is 0. They wait; there is no starvation.
- **Single-beat packet:** `req` and `last` set together; the grant releases after one beat.
- **Asynchronous reset mid-packet:** abandons the packet immediately; all outputs go to their reset values.

## Timing
- Grant latency: `req` in IDLE at cycle N gives `gnt`/`sel` valid at N+1; the first beat can be taken at N+1.
- Data latency: a beat taken at cycle N appears on `o`/`o_valid` at N+1.
- Packet turnaround: the last beat taken at N puts the arbiter in IDLE at N+1 and the next grant at N+2. There is exactly one bubble cycle between packets.
- Throughput: one beat per cycle while `req[sel]` and `o_ready` are held high.
- `sel` and `gnt` change only on the IDLE->BUSY transition and on release, never mid-packet.

## Structure
- Package `box_arb_pkg` holds:
  - `NUM_REQ`=8 and `SEL_W`=3.
  - State enum {IDLE, BUSY}.
  - The one-hot-from-index helper function.
- Sub-module `rr_pick` is combinational: inputs `req[7:0]` and `ptr[2:0]`; outputs `any` and `idx[2:0]` (rotate, priority-encode, un-rotate).
- Stall counter width: `$clog2(TIMEOUT+1)`, minimum 1.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=8'hFF → all outputs 0. Release → `gnt`=8'h01 and `sel`=0 one cycle later.
- **Round-robin:** `req`=8'hFF, 1-beat packets, `o_ready`=1. Grants go 0,1,…,7,0 in order, one per 2 cycles, with `ptr` wrapping 7->0.
- **Packet hold:** requester 3 sends 4 beats with `last` on beat 4 while `req[5]` stays high. `sel` stays 3 for all 4 beats, `o_last` is set only on the 4th output beat, then grant 5 follows after one bubble.
- **Backpressure:** `o_ready`=0 for 5 cycles mid-packet. `o` and `o_valid` hold, `ack`=0 and `err` stays 0. Resuming gives no lost or duplicated beats.
- **Timeout:** with TIMEOUT=15, requester 2 drops `req` mid-packet. After 15 stalled cycles `err` pulses once, the arbiter goes IDLE, and the next grant goes to the first requester at index ≥3.
- **Reset mid-packet:** assert `rst_n`=0 asynchronously during beat 2. `gnt`, `o_valid` and `o` clear before the next clock edge.
